// File: rtl/clock_strobe_nco_if.sv
// clock_strobe_nco_if: configuration channel of the strobe NCO.
//
// Handshake: the master holds cfg_valid together with cfg_chan/cfg_inc/cfg_en;
// a request is transferred on the rising clk edge where cfg_valid && cfg_ready.
// cfg_ready is combinational in cfg_chan (low only while the addressed
// channel already holds a pending retune) and does not depend on cfg_valid.
//
// Signals:
//   cfg_valid  master->slave  request present
//   cfg_ready  slave->master  addressed channel can take a request
//   cfg_chan   master->slave  target channel (CH_W bits)
//   cfg_inc    master->slave  new phase increment (ACC_W bits)
//   cfg_en     master->slave  new enable state
interface clock_strobe_nco_if #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 24
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_en;

  modport master (
    output cfg_valid, cfg_chan, cfg_inc, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_inc, cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/clock_strobe_nco.sv
// clock_strobe_nco: multi-channel numerically controlled oscillator producing
// one-cycle clock-enable strobes from the system clock. Each channel is a
// phase accumulator; a strobe is the carry out of acc + inc.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   cfg     configuration channel (clock_strobe_nco_if slave modport)
//   stb     per-channel registered strobe, one cycle per accumulator carry
//   locked  per-channel registered lock flag (running and LOCK_CYCLES strobes
//           seen since the last config apply)
module clock_strobe_nco #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_strobe_nco_if.slave    cfg,
  output logic [CHANNELS-1:0]  stb,
  output logic [CHANNELS-1:0]  locked
);

  localparam int         CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CYCLES);

  // Per-channel state
  logic [ACC_W-1:0]    acc_q   [CHANNELS];
  logic [ACC_W-1:0]    acc_d   [CHANNELS];
  logic [ACC_W-1:0]    inc_q   [CHANNELS];
  logic [ACC_W-1:0]    inc_d   [CHANNELS];
  logic [ACC_W-1:0]    p_inc_q [CHANNELS];
  logic [ACC_W-1:0]    p_inc_d [CHANNELS];
  logic [7:0]          lcnt_q  [CHANNELS];
  logic [7:0]          lcnt_d  [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] p_valid_q, p_valid_d;
  logic [CHANNELS-1:0] p_en_q, p_en_d;
  logic [CHANNELS-1:0] stb_q, stb_d;
  logic [CHANNELS-1:0] locked_q, locked_d;
  logic                cfg_ready_w;

  // Ready depends only on the addressed channel's pending slot. Channel
  // numbers at or above CHANNELS match nothing, so they stay ready and the
  // accepted request falls on the floor.
  always_comb begin
    cfg_ready_w = 1'b1;
    for (int n = 0; n < CHANNELS; n++) begin
      if (cfg.cfg_chan == CH_W'(n)) begin
        cfg_ready_w = !p_valid_q[n];
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_w;

  always_comb begin
    logic [ACC_W:0] sum;
    logic           running;
    logic           carry;
    logic           hit;
    sum     = '0;
    running = 1'b0;
    carry   = 1'b0;
    hit     = 1'b0;
    for (int n = 0; n < CHANNELS; n++) begin
      running = en_q[n] && (inc_q[n] != '0);
      sum     = {1'b0, acc_q[n]} + {1'b0, inc_q[n]};
      carry   = running && sum[ACC_W];
      hit     = cfg.cfg_valid && (cfg.cfg_chan == CH_W'(n)) && !p_valid_q[n];

      acc_d[n]     = acc_q[n];
      inc_d[n]     = inc_q[n];
      en_d[n]      = en_q[n];
      p_valid_d[n] = p_valid_q[n];
      p_inc_d[n]   = p_inc_q[n];
      p_en_d[n]    = p_en_q[n];
      lcnt_d[n]    = lcnt_q[n];
      stb_d[n]     = 1'b0;

      if (running) begin
        acc_d[n] = sum[ACC_W-1:0];
        stb_d[n] = carry;
        if (carry && (lcnt_q[n] < LOCK_MAX)) begin
          lcnt_d[n] = lcnt_q[n] + 8'd1;
        end
      end

      // Pending retune lands on a carry edge: the wrapped remainder is kept
      // and the strobe for the old rate still fires, so the output phase is
      // continuous across the change.
      if (carry && p_valid_q[n]) begin
        inc_d[n]     = p_inc_q[n];
        en_d[n]      = p_en_q[n];
        p_valid_d[n] = 1'b0;
        lcnt_d[n]    = '0;
      end

      // hit implies an empty slot, so it never collides with the apply above.
      // A request accepted on a carry edge is parked, not consumed by that carry.
      if (hit) begin
        if (!running || !cfg.cfg_en) begin
          acc_d[n]     = '0;
          inc_d[n]     = cfg.cfg_inc;
          en_d[n]      = cfg.cfg_en;
          p_valid_d[n] = 1'b0;
          stb_d[n]     = 1'b0;
          lcnt_d[n]    = '0;
        end else begin
          p_valid_d[n] = 1'b1;
          p_inc_d[n]   = cfg.cfg_inc;
          p_en_d[n]    = cfg.cfg_en;
        end
      end

      locked_d[n] = en_d[n] && (inc_d[n] != '0) && (lcnt_d[n] == LOCK_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        acc_q[n]   <= '0;
        inc_q[n]   <= '0;
        p_inc_q[n] <= '0;
        lcnt_q[n]  <= '0;
      end
      en_q      <= '0;
      p_valid_q <= '0;
      p_en_q    <= '0;
      stb_q     <= '0;
      locked_q  <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        acc_q[n]   <= acc_d[n];
        inc_q[n]   <= inc_d[n];
        p_inc_q[n] <= p_inc_d[n];
        lcnt_q[n]  <= lcnt_d[n];
      end
      en_q      <= en_d;
      p_valid_q <= p_valid_d;
      p_en_q    <= p_en_d;
      stb_q     <= stb_d;
      locked_q  <= locked_d;
    end
  end

  assign stb    = stb_q;
  assign locked = locked_q;

endmodule
